// File: rtl/cpu_pkg.sv
// Shared opcode values, sequencer step encoding, instruction classes and the
// control-word layout used by the control sequencer.
package cpu_pkg;

  localparam logic [4:0] OP_LD   = 5'd0;
  localparam logic [4:0] OP_LDI  = 5'd1;
  localparam logic [4:0] OP_ST   = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_SHR  = 5'd7;
  localparam logic [4:0] OP_SHRA = 5'd8;
  localparam logic [4:0] OP_SHL  = 5'd9;
  localparam logic [4:0] OP_ROR  = 5'd10;
  localparam logic [4:0] OP_ROL  = 5'd11;
  localparam logic [4:0] OP_ADDI = 5'd12;
  localparam logic [4:0] OP_ANDI = 5'd13;
  localparam logic [4:0] OP_ORI  = 5'd14;
  localparam logic [4:0] OP_MUL  = 5'd15;
  localparam logic [4:0] OP_DIV  = 5'd16;
  localparam logic [4:0] OP_NEG  = 5'd17;
  localparam logic [4:0] OP_NOT  = 5'd18;
  localparam logic [4:0] OP_BR   = 5'd19;
  localparam logic [4:0] OP_JR   = 5'd20;
  localparam logic [4:0] OP_JAL  = 5'd21;
  localparam logic [4:0] OP_IN   = 5'd22;
  localparam logic [4:0] OP_OUT  = 5'd23;
  localparam logic [4:0] OP_MFHI = 5'd24;
  localparam logic [4:0] OP_MFLO = 5'd25;
  localparam logic [4:0] OP_NOP  = 5'd26;
  localparam logic [4:0] OP_HALT = 5'd27;

  typedef enum logic [3:0] {
    StIdle, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT7, StHalt
  } step_e;

  typedef enum logic [3:0] {
    CLS_ALU_R, CLS_ALU_I, CLS_MULDIV, CLS_UNARY, CLS_LDST, CLS_BR,
    CLS_JR, CLS_JAL, CLS_IO, CLS_MFX, CLS_NOP, CLS_HALT
  } cls_e;

  typedef struct packed {
    logic [4:0] alu_op;
    logic pc_out, pc_in, incpc, mar_in, mdr_in, mdr_out, read, write;
    logic ir_in, y_in, z_in, zlo_out, zhi_out, hi_in, lo_in, hi_out;
    logic lo_out, gra, grb, grc, r_in, r_out, ba_out, c_out;
    logic con_in, link_in, inport_out, outport_in;
  } ctrl_t;

endpackage

// File: rtl/cu_class_decode.sv
// Combinational opcode-to-instruction-class decoder; unassigned opcodes
// fall into the no-operation class.
module cu_class_decode
  import cpu_pkg::*;
(
  input  logic [4:0] opcode_i,
  output logic [3:0] cls_o
);

  always_comb begin
    cls_o = CLS_NOP;
    case (opcode_i)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
      OP_SHRA, OP_SHL, OP_ROR, OP_ROL:    cls_o = CLS_ALU_R;
      OP_ADDI, OP_ANDI, OP_ORI:           cls_o = CLS_ALU_I;
      OP_MUL, OP_DIV:                     cls_o = CLS_MULDIV;
      OP_NEG, OP_NOT:                     cls_o = CLS_UNARY;
      OP_LD, OP_LDI, OP_ST:               cls_o = CLS_LDST;
      OP_BR:                              cls_o = CLS_BR;
      OP_JR:                              cls_o = CLS_JR;
      OP_JAL:                             cls_o = CLS_JAL;
      OP_IN, OP_OUT:                      cls_o = CLS_IO;
      OP_MFHI, OP_MFLO:                   cls_o = CLS_MFX;
      OP_HALT:                            cls_o = CLS_HALT;
      default:                            cls_o = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle control unit: fetch T0-T2, per-class execute T3-T7, then back to
// fetch. All strobes are a Moore decode of (step, opcode); br T6 also uses con_ff.
module control_sequencer
  import cpu_pkg::*;
(
  input  logic        clk_i,
  input  logic        clr_ni,
  input  logic [31:0] ir_i,
  input  logic        con_ff_i,
  output logic [4:0]  alu_op_o,
  output logic        pc_out_o, pc_in_o, incpc_o, mar_in_o, mdr_in_o, mdr_out_o,
  output logic        read_o, write_o, ir_in_o, y_in_o, z_in_o, zlo_out_o, zhi_out_o,
  output logic        hi_in_o, lo_in_o, hi_out_o, lo_out_o, gra_o, grb_o, grc_o,
  output logic        r_in_o, r_out_o, ba_out_o, c_out_o, con_in_o, link_in_o,
  output logic        inport_out_o, outport_in_o,
  output logic        run_o
);

  step_e       step_q, step_d;
  ctrl_t       c;
  logic        last;
  logic [3:0]  cls_raw;
  cls_e        cls;
  logic [4:0]  opcode;
  logic        unused_ir;

  assign opcode    = ir_i[31:27];
  assign unused_ir = ^ir_i[26:0];
  assign cls       = cls_e'(cls_raw);

  cu_class_decode u_class_decode (
    .opcode_i (opcode),
    .cls_o    (cls_raw)
  );

  always_ff @(posedge clk_i or negedge clr_ni) begin
    if (!clr_ni) step_q <= StIdle;
    else         step_q <= step_d;
  end

  always_comb begin
    c    = '0;
    last = 1'b0;
    case (step_q)
      StT0: begin
        c.pc_out = 1'b1; c.mar_in = 1'b1; c.incpc = 1'b1; c.z_in = 1'b1; c.alu_op = OP_ADD;
      end
      StT1: begin c.zlo_out = 1'b1; c.pc_in = 1'b1; c.read = 1'b1; c.mdr_in = 1'b1; end
      StT2: begin c.mdr_out = 1'b1; c.ir_in = 1'b1; end
      StT3, StT4, StT5, StT6, StT7: begin
        case (cls)
          CLS_ALU_R, CLS_ALU_I: case (step_q)
            StT3: begin c.grb = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1; end
            StT4: begin
              c.z_in = 1'b1; c.alu_op = opcode;
              if (cls == CLS_ALU_I) c.c_out = 1'b1;
              else begin c.grc = 1'b1; c.r_out = 1'b1; end
            end
            StT5: begin c.zlo_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; last = 1'b1; end
            default: ;
          endcase
          CLS_MULDIV: case (step_q)
            StT3: begin c.gra = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1; end
            StT4: begin c.grb = 1'b1; c.r_out = 1'b1; c.z_in = 1'b1; c.alu_op = opcode; end
            StT5: begin c.zlo_out = 1'b1; c.lo_in = 1'b1; end
            StT6: begin c.zhi_out = 1'b1; c.hi_in = 1'b1; last = 1'b1; end
            default: ;
          endcase
          CLS_UNARY: case (step_q)
            StT3: begin c.grb = 1'b1; c.r_out = 1'b1; c.z_in = 1'b1; c.alu_op = opcode; end
            StT4: begin c.zlo_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; last = 1'b1; end
            default: ;
          endcase
          CLS_LDST: case (step_q)
            StT3: begin c.grb = 1'b1; c.ba_out = 1'b1; c.y_in = 1'b1; end
            StT4: begin c.c_out = 1'b1; c.z_in = 1'b1; c.alu_op = OP_ADD; end
            StT5: begin
              c.zlo_out = 1'b1;
              if (opcode == OP_LDI) begin c.gra = 1'b1; c.r_in = 1'b1; last = 1'b1; end
              else c.mar_in = 1'b1;
            end
            StT6: begin
              c.mdr_in = 1'b1;
              if (opcode == OP_ST) begin c.gra = 1'b1; c.r_out = 1'b1; end
              else c.read = 1'b1;
            end
            StT7: begin
              last = 1'b1;
              if (opcode == OP_ST) c.write = 1'b1;
              else begin c.mdr_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
            end
            default: ;
          endcase
          CLS_BR: case (step_q)
            StT3: begin c.gra = 1'b1; c.r_out = 1'b1; c.con_in = 1'b1; end
            StT4: begin c.pc_out = 1'b1; c.y_in = 1'b1; end
            StT5: begin c.c_out = 1'b1; c.z_in = 1'b1; c.alu_op = OP_ADD; end
            StT6: begin c.zlo_out = 1'b1; c.pc_in = con_ff_i; last = 1'b1; end
            default: ;
          endcase
          CLS_JR: begin c.gra = 1'b1; c.r_out = 1'b1; c.pc_in = 1'b1; last = 1'b1; end
          CLS_JAL: case (step_q)
            StT3: begin c.pc_out = 1'b1; c.link_in = 1'b1; end
            StT4: begin c.gra = 1'b1; c.r_out = 1'b1; c.pc_in = 1'b1; last = 1'b1; end
            default: ;
          endcase
          CLS_IO: begin
            c.gra = 1'b1; last = 1'b1;
            if (opcode == OP_IN) begin c.inport_out = 1'b1; c.r_in = 1'b1; end
            else begin c.r_out = 1'b1; c.outport_in = 1'b1; end
          end
          CLS_MFX: begin
            c.gra = 1'b1; c.r_in = 1'b1; last = 1'b1;
            if (opcode == OP_MFHI) c.hi_out = 1'b1;
            else c.lo_out = 1'b1;
          end
          default: last = 1'b1;
        endcase
      end
      default: ;
    endcase

    step_d = step_q;
    case (step_q)
      StIdle: step_d = StT0;
      StHalt: step_d = StHalt;
      // T7 is the deepest step of any class, so it always closes the instruction
      StT7:   step_d = StT0;
      default: begin
        if (step_q == StT3 && cls == CLS_HALT) step_d = StHalt;
        else if (last)                         step_d = StT0;
        else                                   step_d = step_e'(step_q + 4'd1);
      end
    endcase
  end

  assign run_o        = (step_q != StIdle) && (step_q != StHalt);
  assign alu_op_o     = c.alu_op;
  assign pc_out_o     = c.pc_out;
  assign pc_in_o      = c.pc_in;
  assign incpc_o      = c.incpc;
  assign mar_in_o     = c.mar_in;
  assign mdr_in_o     = c.mdr_in;
  assign mdr_out_o    = c.mdr_out;
  assign read_o       = c.read;
  assign write_o      = c.write;
  assign ir_in_o      = c.ir_in;
  assign y_in_o       = c.y_in;
  assign z_in_o       = c.z_in;
  assign zlo_out_o    = c.zlo_out;
  assign zhi_out_o    = c.zhi_out;
  assign hi_in_o      = c.hi_in;
  assign lo_in_o      = c.lo_in;
  assign hi_out_o     = c.hi_out;
  assign lo_out_o     = c.lo_out;
  assign gra_o        = c.gra;
  assign grb_o        = c.grb;
  assign grc_o        = c.grc;
  assign r_in_o       = c.r_in;
  assign r_out_o      = c.r_out;
  assign ba_out_o     = c.ba_out;
  assign c_out_o      = c.c_out;
  assign con_in_o     = c.con_in;
  assign link_in_o    = c.link_in;
  assign inport_out_o = c.inport_out;
  assign outport_in_o = c.outport_in;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench: stimulus queues the hand-written per-cycle control word of
// each instruction; a negedge monitor pops and compares one word per cycle.
module tb_control_sequencer;

  localparam logic [27:0] PC_OUT     = 28'd1 << 27;
  localparam logic [27:0] PC_IN      = 28'd1 << 26;
  localparam logic [27:0] INCPC      = 28'd1 << 25;
  localparam logic [27:0] MAR_IN     = 28'd1 << 24;
  localparam logic [27:0] MDR_IN     = 28'd1 << 23;
  localparam logic [27:0] MDR_OUT    = 28'd1 << 22;
  localparam logic [27:0] READ       = 28'd1 << 21;
  localparam logic [27:0] WRITE      = 28'd1 << 20;
  localparam logic [27:0] IR_IN      = 28'd1 << 19;
  localparam logic [27:0] Y_IN       = 28'd1 << 18;
  localparam logic [27:0] Z_IN       = 28'd1 << 17;
  localparam logic [27:0] ZLO_OUT    = 28'd1 << 16;
  localparam logic [27:0] ZHI_OUT    = 28'd1 << 15;
  localparam logic [27:0] HI_IN      = 28'd1 << 14;
  localparam logic [27:0] LO_IN      = 28'd1 << 13;
  localparam logic [27:0] HI_OUT     = 28'd1 << 12;
  localparam logic [27:0] LO_OUT     = 28'd1 << 11;
  localparam logic [27:0] GRA        = 28'd1 << 10;
  localparam logic [27:0] GRB        = 28'd1 << 9;
  localparam logic [27:0] GRC        = 28'd1 << 8;
  localparam logic [27:0] R_IN       = 28'd1 << 7;
  localparam logic [27:0] R_OUT      = 28'd1 << 6;
  localparam logic [27:0] BA_OUT     = 28'd1 << 5;
  localparam logic [27:0] C_OUT      = 28'd1 << 4;
  localparam logic [27:0] CON_IN     = 28'd1 << 3;
  localparam logic [27:0] LINK_IN    = 28'd1 << 2;
  localparam logic [27:0] INPORT_OUT = 28'd1 << 1;
  localparam logic [27:0] OUTPORT_IN = 28'd1 << 0;
  localparam logic [27:0] NONE       = 28'd0;

  logic clk = 1'b0;
  logic clr_n;
  logic [31:0] ir;
  logic con_ff;
  logic [4:0] alu_op;
  logic pc_out, pc_in, incpc, mar_in, mdr_in, mdr_out, read, write, ir_in, y_in, z_in;
  logic zlo_out, zhi_out, hi_in, lo_in, hi_out, lo_out, gra, grb, grc, r_in, r_out;
  logic ba_out, c_out, con_in, link_in, inport_out, outport_in, run;
  logic [33:0] act;

  int n_checks = 0;
  int n_pass   = 0;
  int wr_cnt   = 0;
  string       tag_q[$];
  logic [33:0] val_q[$];

  always #5 clk = ~clk;

  control_sequencer dut (
    .clk_i(clk), .clr_ni(clr_n), .ir_i(ir), .con_ff_i(con_ff), .alu_op_o(alu_op),
    .pc_out_o(pc_out), .pc_in_o(pc_in), .incpc_o(incpc), .mar_in_o(mar_in),
    .mdr_in_o(mdr_in), .mdr_out_o(mdr_out), .read_o(read), .write_o(write),
    .ir_in_o(ir_in), .y_in_o(y_in), .z_in_o(z_in), .zlo_out_o(zlo_out),
    .zhi_out_o(zhi_out), .hi_in_o(hi_in), .lo_in_o(lo_in), .hi_out_o(hi_out),
    .lo_out_o(lo_out), .gra_o(gra), .grb_o(grb), .grc_o(grc), .r_in_o(r_in),
    .r_out_o(r_out), .ba_out_o(ba_out), .c_out_o(c_out), .con_in_o(con_in),
    .link_in_o(link_in), .inport_out_o(inport_out), .outport_in_o(outport_in),
    .run_o(run)
  );

  assign act = {run, alu_op, pc_out, pc_in, incpc, mar_in, mdr_in, mdr_out, read, write,
                ir_in, y_in, z_in, zlo_out, zhi_out, hi_in, lo_in, hi_out, lo_out, gra, grb,
                grc, r_in, r_out, ba_out, c_out, con_in, link_in, inport_out, outport_in};

  task automatic check(input string nm, input logic [33:0] got, input logic [33:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", nm, got, exp);
  endtask

  function automatic logic [33:0] ev(input logic [4:0] op, input logic [27:0] s);
    return {1'b1, op, s};
  endfunction

  // Monitor: one queued control word is due in every cycle that has one.
  always @(negedge clk) begin
    if (write) wr_cnt++;
    if (val_q.size() > 0) check(tag_q.pop_front(), act, val_q.pop_front());
  end

  task automatic push_n(input string nm, input int k, input logic [33:0] v);
    for (int i = 0; i < k; i++) begin
      tag_q.push_back($sformatf("%s #%0d", nm, i));
      val_q.push_back(v);
    end
  endtask

  task automatic exp_push(input string nm, inout int n, input int lim, input logic [33:0] v);
    if (lim == 0 || n < lim) begin
      tag_q.push_back($sformatf("%s T%0d", nm, n));
      val_q.push_back(v);
    end
    n++;
  endtask

  task automatic wait_cyc(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // Called right after the edge that enters T0; lim>0 truncates the instruction.
  task automatic run_instr(input string nm, input logic [4:0] op, input logic cf,
                           input int lim);
    int n = 0;
    ir     = {op, 27'h5A5A5A5};
    con_ff = cf;
    exp_push(nm, n, lim, ev(5'd3, PC_OUT | MAR_IN | INCPC | Z_IN));
    exp_push(nm, n, lim, ev(5'd0, ZLO_OUT | PC_IN | READ | MDR_IN));
    exp_push(nm, n, lim, ev(5'd0, MDR_OUT | IR_IN));
    case (op)
      5'd3, 5'd4: begin
        exp_push(nm, n, lim, ev(5'd0, GRB | R_OUT | Y_IN));
        exp_push(nm, n, lim, ev(op, GRC | R_OUT | Z_IN));
        exp_push(nm, n, lim, ev(5'd0, ZLO_OUT | GRA | R_IN));
      end
      5'd12: begin
        exp_push(nm, n, lim, ev(5'd0, GRB | R_OUT | Y_IN));
        exp_push(nm, n, lim, ev(op, C_OUT | Z_IN));
        exp_push(nm, n, lim, ev(5'd0, ZLO_OUT | GRA | R_IN));
      end
      5'd15, 5'd16: begin
        exp_push(nm, n, lim, ev(5'd0, GRA | R_OUT | Y_IN));
        exp_push(nm, n, lim, ev(op, GRB | R_OUT | Z_IN));
        exp_push(nm, n, lim, ev(5'd0, ZLO_OUT | LO_IN));
        exp_push(nm, n, lim, ev(5'd0, ZHI_OUT | HI_IN));
      end
      5'd17, 5'd18: begin
        exp_push(nm, n, lim, ev(op, GRB | R_OUT | Z_IN));
        exp_push(nm, n, lim, ev(5'd0, ZLO_OUT | GRA | R_IN));
      end
      5'd0, 5'd1, 5'd2: begin
        exp_push(nm, n, lim, ev(5'd0, GRB | BA_OUT | Y_IN));
        exp_push(nm, n, lim, ev(5'd3, C_OUT | Z_IN));
        if (op == 5'd1) exp_push(nm, n, lim, ev(5'd0, ZLO_OUT | GRA | R_IN));
        else begin
          exp_push(nm, n, lim, ev(5'd0, ZLO_OUT | MAR_IN));
          if (op == 5'd0) begin
            exp_push(nm, n, lim, ev(5'd0, READ | MDR_IN));
            exp_push(nm, n, lim, ev(5'd0, MDR_OUT | GRA | R_IN));
          end else begin
            exp_push(nm, n, lim, ev(5'd0, GRA | R_OUT | MDR_IN));
            exp_push(nm, n, lim, ev(5'd0, WRITE));
          end
        end
      end
      5'd19: begin
        exp_push(nm, n, lim, ev(5'd0, GRA | R_OUT | CON_IN));
        exp_push(nm, n, lim, ev(5'd0, PC_OUT | Y_IN));
        exp_push(nm, n, lim, ev(5'd3, C_OUT | Z_IN));
        exp_push(nm, n, lim, ev(5'd0, ZLO_OUT | (cf ? PC_IN : NONE)));
      end
      5'd20: exp_push(nm, n, lim, ev(5'd0, GRA | R_OUT | PC_IN));
      5'd21: begin
        exp_push(nm, n, lim, ev(5'd0, PC_OUT | LINK_IN));
        exp_push(nm, n, lim, ev(5'd0, GRA | R_OUT | PC_IN));
      end
      5'd22: exp_push(nm, n, lim, ev(5'd0, INPORT_OUT | GRA | R_IN));
      5'd23: exp_push(nm, n, lim, ev(5'd0, GRA | R_OUT | OUTPORT_IN));
      5'd24: exp_push(nm, n, lim, ev(5'd0, HI_OUT | GRA | R_IN));
      5'd25: exp_push(nm, n, lim, ev(5'd0, LO_OUT | GRA | R_IN));
      default: exp_push(nm, n, lim, ev(5'd0, NONE));
    endcase
    wait_cyc(lim == 0 ? n : lim);
  endtask

  initial begin
    int w0;
    clr_n  = 1'b0;
    ir     = 32'd0;
    con_ff = 1'b0;
    @(posedge clk); #1;
    push_n("reset", 3, 34'd0);
    wait_cyc(3);
    clr_n = 1'b1;
    push_n("idle", 1, 34'd0);
    wait_cyc(1);

    run_instr("add",   5'd3,  1'b0, 0);
    run_instr("addi",  5'd12, 1'b0, 0);
    run_instr("mul",   5'd15, 1'b0, 0);
    run_instr("neg",   5'd17, 1'b0, 0);
    run_instr("ldi",   5'd1,  1'b0, 0);
    run_instr("ld",    5'd0,  1'b0, 0);
    w0 = wr_cnt;
    run_instr("st",    5'd2,  1'b0, 0);
    check("st write count", 34'(wr_cnt - w0), 34'd1);
    run_instr("br1",   5'd19, 1'b1, 0);
    run_instr("br0",   5'd19, 1'b0, 0);
    run_instr("jr",    5'd20, 1'b0, 0);
    run_instr("jal",   5'd21, 1'b0, 0);
    run_instr("in",    5'd22, 1'b0, 0);
    run_instr("out",   5'd23, 1'b0, 0);
    run_instr("mfhi",  5'd24, 1'b0, 0);
    run_instr("mflo",  5'd25, 1'b0, 0);
    run_instr("nop",   5'd26, 1'b0, 0);
    run_instr("undef", 5'd30, 1'b0, 0);
    run_instr("halt",  5'd27, 1'b0, 0);
    push_n("halted", 20, 34'd0);
    wait_cyc(20);

    clr_n = 1'b0;
    push_n("halt reset", 1, 34'd0);
    wait_cyc(1);
    clr_n = 1'b1;
    push_n("halt idle", 1, 34'd0);
    wait_cyc(1);

    // Enter st T6, then pull reset: outputs must drop before the sample point.
    w0 = wr_cnt;
    run_instr("st_abort", 5'd2, 1'b0, 6);
    clr_n = 1'b0;
    push_n("abort reset", 2, 34'd0);
    wait_cyc(2);
    clr_n = 1'b1;
    push_n("abort idle", 1, 34'd0);
    wait_cyc(1);
    run_instr("add2", 5'd4, 1'b0, 0);
    check("aborted st write count", 34'(wr_cnt - w0), 34'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
